// File: rtl/sc_lane_shifter.sv
// Rotating lane pattern shifter: a load/run/pause FSM that rotates a vehicle pattern on prescaler ticks.
// Optional revolution-detect pulse (and its step counter) is built only when SC_LANE_WRAP_EN is defined.
module sc_lane_shifter #(
  parameter int LANE_WIDTH = 8,
  parameter int STEP_WIDTH = 3
) (
  input  logic                  SC_RECLOCK_CLOCK_50,
  input  logic                  SC_RECLOCK_RESET,
  input  logic                  SC_LANE_TICK_N_In,
  input  logic                  SC_LANE_LOAD_In,
  input  logic [LANE_WIDTH-1:0] SC_LANE_DATA_In,
  input  logic                  SC_LANE_DIR_In,
  input  logic                  SC_LANE_PAUSE_In,
  input  logic                  SC_LANE_CLEAR_In,
  output logic [LANE_WIDTH-1:0] SC_LANE_Out,
  output logic                  SC_LANE_RUN_Out,
  output logic                  SC_LANE_WRAP_Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LANE_WIDTH-1:0] lane_q, lane_d;
  logic                  tick_prev_q, tick_prev_d;
  logic                  armed_q, armed_d;
  logic                  tick;

  // armed_q masks the first edge after reset, so a TICK_N already low then is not a tick.
  always_comb begin
    tick        = armed_q & tick_prev_q & ~SC_LANE_TICK_N_In;
    tick_prev_d = SC_LANE_TICK_N_In;
    armed_d     = 1'b1;
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    if (SC_LANE_CLEAR_In) begin
      state_d = ST_IDLE;
      lane_d  = '0;
    end else if (SC_LANE_LOAD_In) begin
      lane_d  = SC_LANE_DATA_In;
      state_d = SC_LANE_PAUSE_In ? ST_PAUSE : ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (tick) begin
            lane_d = SC_LANE_DIR_In ? {lane_q[0], lane_q[LANE_WIDTH-1:1]}
                                    : {lane_q[LANE_WIDTH-2:0], lane_q[LANE_WIDTH-1]};
          end
          if (SC_LANE_PAUSE_In) state_d = ST_PAUSE;
        end
        ST_PAUSE: if (!SC_LANE_PAUSE_In) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SC_RECLOCK_CLOCK_50 or posedge SC_RECLOCK_RESET) begin
    if (SC_RECLOCK_RESET) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      tick_prev_q <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      tick_prev_q <= tick_prev_d;
      armed_q     <= armed_d;
    end
  end

  assign SC_LANE_Out     = lane_q;
  assign SC_LANE_RUN_Out = (state_q == ST_RUN);

`ifdef SC_LANE_WRAP_EN
  localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(LANE_WIDTH - 1);

  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  wrap_q, wrap_d;
  logic                  rotate;

  // Same qualification as the rotation path above: RUN, tick, no clear/load.
  always_comb begin
    rotate = (state_q == ST_RUN) & tick & ~SC_LANE_CLEAR_In & ~SC_LANE_LOAD_In;
    step_d = step_q;
    wrap_d = 1'b0;
    if (SC_LANE_CLEAR_In || SC_LANE_LOAD_In) begin
      step_d = '0;
    end else if (rotate) begin
      if (step_q == STEP_LAST) begin
        step_d = '0;
        wrap_d = 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  always_ff @(posedge SC_RECLOCK_CLOCK_50 or posedge SC_RECLOCK_RESET) begin
    if (SC_RECLOCK_RESET) begin
      step_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign SC_LANE_WRAP_Out = wrap_q;
`else
  assign SC_LANE_WRAP_Out = 1'b0;
`endif

endmodule

// File: tb/tb_sc_lane_shifter.sv
// Directed bench for sc_lane_shifter: expected lane/run/wrap values are queued as each step is
// driven and compared after the clock edge that should produce them.
module tb_sc_lane_shifter;

`ifdef SC_LANE_WRAP_EN
  localparam logic WRAP_ON = 1'b1;
`else
  localparam logic WRAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_n = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data = 8'h00;
  logic       dir = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] lane_out;
  logic       run_out;
  logic       wrap_out;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [7:0] lane;
    logic       run;
    logic       wrap;
  } exp_t;

  exp_t sb[$];

  sc_lane_shifter #(.LANE_WIDTH(8), .STEP_WIDTH(3)) dut (
    .SC_RECLOCK_CLOCK_50(clk),
    .SC_RECLOCK_RESET   (rst),
    .SC_LANE_TICK_N_In  (tick_n),
    .SC_LANE_LOAD_In    (load),
    .SC_LANE_DATA_In    (data),
    .SC_LANE_DIR_In     (dir),
    .SC_LANE_PAUSE_In   (pause),
    .SC_LANE_CLEAR_In   (clear),
    .SC_LANE_Out        (lane_out),
    .SC_LANE_RUN_Out    (run_out),
    .SC_LANE_WRAP_Out   (wrap_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, let one rising edge happen, then sample 1 time unit later.
  task automatic cycle(input string tag, input logic [7:0] l, input logic r, input logic w);
    exp_t e;
    sb.push_back('{tag, l, r, w});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_lane"}, lane_out, e.lane);
    check({e.tag, "_run"}, {7'd0, run_out}, {7'd0, e.run});
    check({e.tag, "_wrap"}, {7'd0, wrap_out}, {7'd0, e.wrap});
  endtask

  // One single-cycle tick: TICK_N low for one edge, then high again.
  task automatic tick_once(input string tag, input logic [7:0] l, input logic r);
    tick_n = 1'b0;
    cycle({tag, "_lo"}, l, r, 1'b0);
    tick_n = 1'b1;
    cycle({tag, "_hi"}, l, r, 1'b0);
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  initial begin
    logic [7:0] model;

    // Reset state, with TICK_N held low across release.
    #2;
    check("reset_lane", lane_out, 8'h00);
    check("reset_run", {7'd0, run_out}, 8'h00);
    check("reset_wrap", {7'd0, wrap_out}, 8'h00);
    tick_n = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst_low_tick", 8'h00, 1'b0, 1'b0);
    tick_n = 1'b1;
    cycle("post_rst_idle", 8'h00, 1'b0, 1'b0);

    // Rotation both directions.
    load = 1'b1; data = 8'h81; dir = 1'b0;
    cycle("load_81", 8'h81, 1'b1, 1'b0);
    load = 1'b0;
    tick_once("rotl_1", 8'h03, 1'b1);
    tick_once("rotl_2", 8'h06, 1'b1);
    tick_once("rotl_3", 8'h0C, 1'b1);
    dir = 1'b1;
    tick_once("rotr_1", 8'h06, 1'b1);

    // A five-cycle low TICK_N is one tick.
    tick_n = 1'b0;
    cycle("wide_tick_1", 8'h03, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("wide_tick_hold", 8'h03, 1'b1, 1'b0);
    tick_n = 1'b1;
    cycle("wide_tick_rel", 8'h03, 1'b1, 1'b0);

    // Load wins over a coincident tick; clear wins over load.
    dir = 1'b0; load = 1'b1; data = 8'h0F; tick_n = 1'b0;
    cycle("load_vs_tick", 8'h0F, 1'b1, 1'b0);
    load = 1'b0;
    cycle("load_vs_tick_hold", 8'h0F, 1'b1, 1'b0);
    tick_n = 1'b1;
    cycle("load_vs_tick_rel", 8'h0F, 1'b1, 1'b0);
    clear = 1'b1; load = 1'b1; data = 8'hFF;
    cycle("clear_vs_load", 8'h00, 1'b0, 1'b0);
    clear = 1'b0; load = 1'b0;
    tick_once("idle_tick", 8'h00, 1'b0);

    // Pause: ticks while paused are dropped, not queued.
    load = 1'b1; data = 8'h11;
    cycle("load_11", 8'h11, 1'b1, 1'b0);
    load = 1'b0; pause = 1'b1;
    cycle("pause_enter", 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick_once("paused_tick", 8'h11, 1'b0);
    pause = 1'b0;
    cycle("pause_exit", 8'h11, 1'b1, 1'b0);
    cycle("pause_exit_idle", 8'h11, 1'b1, 1'b0);
    tick_once("after_pause", 8'h22, 1'b1);

    // Full revolution: 8 ticks return the loaded value; wrap pulses on the 8th only.
    load = 1'b1; data = 8'hA5;
    cycle("load_a5", 8'hA5, 1'b1, 1'b0);
    load = 1'b0;
    model = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      model = rotl(model);
      tick_n = 1'b0;
      cycle("rev_lo", model, 1'b1, (i == 7) ? WRAP_ON : 1'b0);
      tick_n = 1'b1;
      cycle("rev_hi", model, 1'b1, 1'b0);
    end
    check("rev_final", lane_out, 8'hA5);

    // Reset mid-RUN discards the lane; ticks after release do nothing until LOAD.
    load = 1'b1; data = 8'h05;
    cycle("load_05", 8'h05, 1'b1, 1'b0);
    load = 1'b0;
    rst = 1'b1;
    #1;
    check("midrun_rst_lane", lane_out, 8'h00);
    check("midrun_rst_run", {7'd0, run_out}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick_once("post_rst_tick_1", 8'h00, 1'b0);
    tick_once("post_rst_tick_2", 8'h00, 1'b0);
    load = 1'b1; data = 8'h3C;
    cycle("reload_3c", 8'h3C, 1'b1, 1'b0);
    load = 1'b0;
    tick_once("reload_rot", 8'h78, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sc_lane_shifter.md
SC_LANE_SHIFTER -- requirements
Module: sc_lane_shifter

Interface
REQ-001 SHALL provide parameter LANE_WIDTH, default 8, meaning number of lane cells (allowed range 2..32).
REQ-002 SHALL provide parameter STEP_WIDTH, default 3, meaning step counter width; 2**STEP_WIDTH SHALL be >= LANE_WIDTH.
REQ-003 SHALL provide port SC_RECLOCK_CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL provide port SC_RECLOCK_RESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port SC_LANE_TICK_N_In  in  1  prescaler tick, idle high, one or more cycles low per tick.
REQ-006 SHALL provide port SC_LANE_LOAD_In  in  1  load pulse; captures SC_LANE_DATA_In.
REQ-007 SHALL provide port SC_LANE_DATA_In  in  LANE_WIDTH  initial vehicle pattern, 1 = vehicle.
REQ-008 SHALL provide port SC_LANE_DIR_In  in  1  0 = rotate toward MSB, 1 = rotate toward LSB.
REQ-009 SHALL provide port SC_LANE_PAUSE_In  in  1  level; holds the lane while high.
REQ-010 SHALL provide port SC_LANE_CLEAR_In  in  1  synchronous clear to IDLE.
REQ-011 SHALL provide port SC_LANE_Out  out  LANE_WIDTH  registered lane pattern.
REQ-012 SHALL provide port SC_LANE_RUN_Out  out  1  high while state is RUN.
REQ-013 SHALL provide port SC_LANE_WRAP_Out  out  1  one-cycle pulse on pattern full revolution (feature-gated, REQ-030).

Function
REQ-014 SHALL detect a tick when registered previous TICK_N sample is 1 and current sample is 0; previous-sample register resets to 1.
REQ-015 SHALL treat a TICK_N low lasting several cycles as a single tick.
REQ-016 SHALL implement states IDLE, RUN, PAUSE, registered, encoded in 2 bits.
REQ-017 SHALL transition IDLE -> RUN on LOAD; RUN -> PAUSE when PAUSE_In = 1; PAUSE -> RUN when PAUSE_In = 0.
REQ-018 SHALL transition any state -> IDLE on CLEAR and set SC_LANE_Out to 0; CLEAR has priority over LOAD and tick.
REQ-019 SHALL on LOAD (no CLEAR) in any state capture DATA_In into SC_LANE_Out at the same edge, reset step counter to 0, enter RUN (or PAUSE if PAUSE_In = 1).
REQ-020 SHALL on tick in RUN with no LOAD/CLEAR rotate at the detecting edge: DIR=0 -> {lane[W-2:0], lane[W-1]}; DIR=1 -> {lane[0], lane[W-1:1]}.
REQ-021 SHALL ignore and not queue ticks in IDLE, PAUSE, or coinciding with LOAD/CLEAR.
REQ-022 SHALL maintain a step counter incremented per rotation, wrapping from LANE_WIDTH-1 to 0; DIR changes do not reset it.
REQ-023 SHALL hold SC_LANE_Out unchanged in IDLE and PAUSE.
REQ-024 SHALL drive SC_LANE_RUN_Out combinationally from state register only.

Reset
REQ-025 SHALL on SC_RECLOCK_RESET = 1, independent of clock, set state IDLE, SC_LANE_Out 0, step counter 0, previous tick sample 1, WRAP_Out 0.
REQ-026 SHALL, when reset asserts mid-RUN, discard lane contents; after release, require LOAD before any rotation.
REQ-027 SHALL not detect a tick on the first edge after reset release if TICK_N is already low.

Configuration
REQ-028 SHALL gate the revolution-detect feature with macro SC_LANE_WRAP_EN.
REQ-029 SHALL, with SC_LANE_WRAP_EN defined, pulse SC_LANE_WRAP_Out high for exactly one cycle at the edge where the step counter wraps LANE_WIDTH-1 -> 0.
REQ-030 SHALL, without SC_LANE_WRAP_EN, tie SC_LANE_WRAP_Out to constant 0 and remove the step counter logic; all other behaviour unchanged.

Verification
REQ-031 SHALL verify reset: assert reset mid-RUN with lane 8'b0000_0101 -> SC_LANE_Out = 0, RUN_Out = 0 immediately; ticks after release ignored.
REQ-032 SHALL verify rotation: LOAD 8'b1000_0001, DIR=0, three ticks -> 8'b0000_0011, 8'b0000_0110, 8'b0000_1100; DIR=1 next tick -> 8'b0000_0110.
REQ-033 SHALL verify tick width: TICK_N low 5 cycles -> exactly one rotation.
REQ-034 SHALL verify priority: LOAD 8'h0F with tick same cycle -> lane = 8'h0F, no rotation; CLEAR+LOAD same cycle -> lane 0, IDLE.
REQ-035 SHALL verify pause: PAUSE high over 3 ticks -> lane unchanged, no queued shifts after release; next tick shifts once.
REQ-036 SHALL verify wrap (SC_LANE_WRAP_EN): LOAD then 8 ticks -> lane equals loaded value, WRAP_Out high one cycle at 8th tick; without macro WRAP_Out stays 0.
